// File: rtl/sc_umul.sv
// sc_umul: unipolar stochastic multiplier, oC = iA & (B > bitrev(cnt)).
// Define UMUL_OUT_REG_EN to register oC (one cycle of latency).
module sc_umul #(
  parameter int INWD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iA,
  input  logic [INWD-1:0] iB,
  input  logic            loadB,
  output logic            oC
);
  logic [INWD-1:0] b_reg;
  logic [INWD-1:0] cnt;
  logic [INWD-1:0] rng;
  logic            hit;
  // van der Corput sequence: bit-reversed counter, advanced only by iA=1
  for (genvar i = 0; i < INWD; i++) begin : g_rev
    assign rng[i] = cnt[INWD-1-i];
  end
  assign hit = iA & (b_reg > rng);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      b_reg <= '0;
      cnt   <= '0;
    end else begin
      if (loadB) b_reg <= iB;
      if (iA) cnt <= cnt + 1'b1;
    end
`ifdef UMUL_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) oC <= 1'b0;
    else oC <= hit;
`else
  assign oC = hit;
`endif
endmodule

// File: tb/tb_sc_umul.sv
// tb_sc_umul: scoreboard bench for sc_umul (combinational-output build).
module tb_sc_umul;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       iA = 0;
  logic [7:0] iB = 0;
  logic       loadB = 0;
  logic       oC;
  int         total = 0;
  int         bad = 0;
  int         ones = 0;
  typedef struct {
    logic  c;
    logic  e;
    logic  s;
    logic  w;
    int    eo;
    string n;
  } ent_t;
  ent_t q[$];

  sc_umul #(.INWD(8)) dut (
    .clk(clk), .rst_n(rst_n), .iA(iA), .iB(iB), .loadB(loadB), .oC(oC)
  );

  always #5 clk = ~clk;

  // one cycle of stimulus: c=check bit e, s=start window, w=end window expecting eo ones
  task automatic cyc(input logic a, input logic ld, input logic [7:0] b, input logic c,
                     input logic e, input string n, input logic s = 0, input logic w = 0,
                     input int eo = 0);
    ent_t t;
    @(posedge clk);
    #1;
    iA = a;
    loadB = ld;
    iB = b;
    t.c = c; t.e = e; t.s = s; t.w = w; t.eo = eo; t.n = n;
    q.push_back(t);
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      ent_t t;
      t = q.pop_front();
      if (t.s) ones = 0;
      if (oC === 1'b1) ones++;
      if (t.c) begin
        total++;
        if (oC !== t.e) begin
          bad++;
          $display("FAIL %s: oC=%b expected %b", t.n, oC, t.e);
        end
      end
      if (t.w) begin
        total++;
        if (ones != t.eo) begin
          bad++;
          $display("FAIL %s count: ones=%0d expected %0d", t.n, ones, t.eo);
        end
        ones = 0;
      end
    end

  initial begin
    int c;
    for (int k = 0; k < 4; k++) cyc(1, k[0], 8'd128, 1, 0, "reset");
    cyc(1, 0, 8'd0, 1, 0, "breg_zero");
    rst_n = 1;
    cyc(0, 0, 8'd0, 1, 0, "pulse");
    rst_n = 0;
    cyc(0, 1, 8'd128, 1, 0, "load128");
    rst_n = 1;
    // B=128: ones exactly on even cnt values
    for (int k = 0; k < 50; k++) cyc(1, 0, 8'd0, 1, (k % 2) == 0, "b128", k == 0, k == 49, 25);
    for (int k = 0; k < 5; k++) cyc(0, 0, 8'd0, 1, 0, "ia_low");
    cyc(1, 0, 8'd0, 1, 1, "frozen50");
    cyc(1, 0, 8'd0, 1, 0, "frozen51");
    cyc(0, 1, 8'd77, 1, 0, "load77");
    for (int k = 0; k < 256; k++) cyc(1, 0, 8'd0, 0, 0, "b77", k == 0, k == 255, 77);
    cyc(0, 1, 8'd0, 1, 0, "load0");
    for (int k = 0; k < 256; k++) cyc(1, 0, 8'd0, 1, 0, "b0", k == 0, k == 255, 0);
    cyc(0, 1, 8'd255, 1, 0, "load255");
    c = 52;
    for (int k = 0; k < 256; k++) begin
      cyc(1, 0, 8'd0, 1, c != 255, "b255", k == 0, k == 255, 255);
      c = (c + 1) % 256;
    end
    cyc(0, 0, 8'd0, 1, 0, "pulse2");
    rst_n = 0;
    cyc(0, 1, 8'd128, 1, 0, "load128g");
    rst_n = 1;
    for (int k = 0; k < 100; k++)
      cyc(k % 2 == 0, 0, 8'd0, 1, (k % 2 == 0) && ((k / 2) % 2 == 0), "gated", k == 0, k == 99, 25);
    cyc(1, 0, 8'd0, 1, 1, "gated_cnt50");
    cyc(1, 0, 8'd0, 1, 0, "gated_cnt51");
    cyc(0, 1, 8'd0, 1, 0, "load0c");
    cyc(1, 1, 8'd255, 1, 0, "collide_old");
    cyc(1, 0, 8'd0, 1, 1, "collide_new53");
    cyc(1, 0, 8'd0, 1, 1, "collide_new54");
    cyc(0, 0, 8'd0, 1, 0, "pulse3");
    rst_n = 0;
    cyc(0, 1, 8'd128, 1, 0, "load128m");
    rst_n = 1;
    for (int k = 0; k < 37; k++) cyc(1, 0, 8'd0, 1, (k % 2) == 0, "mid", k == 0, k == 36, 19);
    cyc(1, 0, 8'd0, 1, 0, "mid_rst");
    rst_n = 0;
    cyc(1, 1, 8'd128, 1, 0, "mid_rst_hold");
    cyc(0, 1, 8'd128, 1, 0, "reload");
    rst_n = 1;
    cyc(1, 0, 8'd0, 1, 1, "restart0");
    cyc(1, 0, 8'd0, 1, 0, "restart1");
    cyc(0, 0, 8'd0, 1, 0, "tail");
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
